// File: rtl/qcw_burst_sequencer.sv
// QCW burst sequencer: relay precharge, settle, PLL start, run and cooldown, with fault latching.
// Define QCW_SEQ_PHASE_RAMP_EN to enable the saturating phase ramp applied during RUN.
module qcw_burst_sequencer #(
  parameter int unsigned PRECHARGE_CYCLES = 16000,
  parameter int unsigned SETTLE_CYCLES    = 1600,
  parameter int unsigned COOLDOWN_CYCLES  = 160000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fire_req,
  input  logic        fault_clear,
  input  logic        uvlo_ok,
  input  logic [15:0] cfg_cycle_limit,
  input  logic [7:0]  cfg_phase_start,
  input  logic [7:0]  cfg_phase_step,
  input  logic [7:0]  cfg_phase_max,
  input  logic        qcw_cycle_finished,
  input  logic        qcw_done,
  input  logic        qcw_fault,
  input  logic        qcw_halt,
  output logic        qcw_start,
  output logic [15:0] qcw_cycle_limit,
  output logic [7:0]  qcw_phase_shift,
  output logic        relay_precharge,
  output logic        relay_main,
  output logic        busy,
  output logic        fault_latched,
  output logic        fire_ack
);

  localparam logic [31:0] PRECHARGE_LOAD = 32'(PRECHARGE_CYCLES - 1);
  localparam logic [31:0] SETTLE_LOAD    = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] COOLDOWN_LOAD  = 32'(COOLDOWN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRECHARGE, S_SETTLE, S_FIRE, S_RUN, S_COOLDOWN, S_FAULT
  } state_e;

  state_e      state;
  logic [31:0] count;
  logic [7:0]  cfg_phase_start_q;
  logic        accept;
  logic        abort;

  assign accept = (state == S_IDLE) && fire_req && uvlo_ok;
  // Any supervisory trip while the relays or PLL are active pre-empts normal sequencing, including qcw_done.
  assign abort  = (state inside {S_PRECHARGE, S_SETTLE, S_FIRE, S_RUN}) &&
                  (qcw_fault || qcw_halt || !uvlo_ok);

`ifdef QCW_SEQ_PHASE_RAMP_EN
  logic [7:0] cfg_phase_step_q;
  logic [7:0] cfg_phase_max_q;
  logic [8:0] phase_sum;
  logic [7:0] phase_next;

  // 9-bit sum so the carry is seen and the ramp clamps at the maximum instead of wrapping.
  always_comb begin
    phase_sum  = {1'b0, qcw_phase_shift} + {1'b0, cfg_phase_step_q};
    phase_next = (phase_sum > {1'b0, cfg_phase_max_q}) ? cfg_phase_max_q : phase_sum[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_phase_step_q <= '0;
      cfg_phase_max_q  <= '0;
    end else if (accept) begin
      cfg_phase_step_q <= cfg_phase_step;
      cfg_phase_max_q  <= cfg_phase_max;
    end
  end
`else
  logic unused_ramp_inputs;
  assign unused_ramp_inputs = ^{cfg_phase_step, cfg_phase_max, qcw_cycle_finished};
`endif

  // NOTE: every registered output is assigned with <= so all of them update together on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      count             <= '0;
      cfg_phase_start_q <= '0;
      qcw_start         <= 1'b0;
      qcw_cycle_limit   <= '0;
      qcw_phase_shift   <= '0;
      relay_precharge   <= 1'b0;
      relay_main        <= 1'b0;
      busy              <= 1'b0;
      fault_latched     <= 1'b0;
      fire_ack          <= 1'b0;
    end else begin
      qcw_start <= 1'b0;
      fire_ack  <= 1'b0;
      if (abort) begin
        state           <= S_FAULT;
        relay_precharge <= 1'b0;
        relay_main      <= 1'b0;
        fault_latched   <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              fire_ack          <= 1'b1;
              busy              <= 1'b1;
              qcw_cycle_limit   <= cfg_cycle_limit;
              cfg_phase_start_q <= cfg_phase_start;
              relay_precharge   <= 1'b1;
              count             <= PRECHARGE_LOAD;
              state             <= S_PRECHARGE;
            end
          end
          S_PRECHARGE: begin
            if (count == '0) begin
              relay_precharge <= 1'b0;
              relay_main      <= 1'b1;
              count           <= SETTLE_LOAD;
              state           <= S_SETTLE;
            end else begin
              count <= count - 32'd1;
            end
          end
          S_SETTLE: begin
            if (count == '0) begin
              qcw_phase_shift <= cfg_phase_start_q;
              qcw_start       <= 1'b1;
              state           <= S_FIRE;
            end else begin
              count <= count - 32'd1;
            end
          end
          S_FIRE: state <= S_RUN;
          S_RUN: begin
`ifdef QCW_SEQ_PHASE_RAMP_EN
            if (qcw_cycle_finished) qcw_phase_shift <= phase_next;
`endif
            if (qcw_done) begin
              relay_main <= 1'b0;
              count      <= COOLDOWN_LOAD;
              state      <= S_COOLDOWN;
            end
          end
          S_COOLDOWN: begin
            if (count == '0) begin
              busy            <= 1'b0;
              qcw_phase_shift <= '0;
              state           <= S_IDLE;
            end else begin
              count <= count - 32'd1;
            end
          end
          S_FAULT: begin
            // Only leave FAULT once the PLL reports idle, so a cleared fault cannot re-arm a live burst.
            if (fault_clear && qcw_done) begin
              fault_latched <= 1'b0;
              count         <= COOLDOWN_LOAD;
              state         <= S_COOLDOWN;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/qcw_burst_sequencer.md
QCW_BURST_SEQUENCER -- requirements
Module: qcw_burst_sequencer

Interface
REQ-001 Parameter PRECHARGE_CYCLES, default 16000, clk cycles with relay_precharge on before relay_main closes.
REQ-002 Parameter SETTLE_CYCLES, default 1600, clk cycles after relay_main closes before qcw_start.
REQ-003 Parameter COOLDOWN_CYCLES, default 160000, minimum clk cycles from qcw_done to the next accepted fire_req.
REQ-004 clk  in  1  system clock (160 MHz); one clock domain; all inputs synchronous to clk.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 fire_req  in  1  level request for one burst; sampled in IDLE only.
REQ-007 fault_clear  in  1  single-cycle pulse; clears the latched fault.
REQ-008 uvlo_ok  in  1  high when the bus voltage is above the undervoltage threshold.
REQ-009 cfg_cycle_limit  in  16  burst length in resonant cycles; captured at fire acceptance.
REQ-010 cfg_phase_start / cfg_phase_step / cfg_phase_max  in  8 each  phase ramp settings; captured at fire acceptance.
REQ-011 qcw_cycle_finished / qcw_done / qcw_fault / qcw_halt  in  1 each  status from the QCW PLL and the OCD.
REQ-012 qcw_start  out  1  single-cycle start pulse to the PLL.
REQ-013 qcw_cycle_limit  out  16  registered copy of the captured cfg_cycle_limit.
REQ-014 qcw_phase_shift  out  8  current phase command.
REQ-015 relay_precharge / relay_main  out  1 each  relay drive; high = closed.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 fault_latched  out  1  high in FAULT.
REQ-018 fire_ack  out  1  single-cycle pulse on fire acceptance.

Function
REQ-019 States: IDLE, PRECHARGE, SETTLE, FIRE, RUN, COOLDOWN, FAULT; one 32-bit down-counter is shared by the timed states.
REQ-020 IDLE: if fire_req=1 and uvlo_ok=1, then fire_ack=1, capture cfg_*, relay_precharge=1, counter=PRECHARGE_CYCLES-1, go to PRECHARGE.
REQ-021 IDLE: if fire_req=1 and uvlo_ok=0, the request is ignored and the state stays IDLE.
REQ-022 PRECHARGE: at counter 0, relay_main=1, relay_precharge=0 on the same edge, counter=SETTLE_CYCLES-1, go to SETTLE.
REQ-023 SETTLE: at counter 0, qcw_phase_shift=cfg_phase_start, qcw_start=1 for exactly one cycle, go to FIRE.
REQ-024 FIRE: the cycle after the pulse, go to RUN; qcw_start=0.
REQ-025 RUN: each qcw_cycle_finished pulse sets phase = min(phase+step, cfg_phase_max), computed 9-bit and saturating, never wrapping; phase updates the cycle after the pulse.
REQ-026 RUN: on qcw_done, relay_main=0, counter=COOLDOWN_CYCLES-1, go to COOLDOWN.
REQ-027 COOLDOWN: at counter 0, go to IDLE; fire_req is ignored throughout COOLDOWN.
REQ-028 qcw_fault=1, qcw_halt=1, or uvlo_ok=0 in PRECHARGE/SETTLE/FIRE/RUN causes the next state to be FAULT, with both relays opened and qcw_start=0 on that edge.
REQ-029 Fault wins over done when both arrive in the same cycle.
REQ-030 FAULT: hold until fault_clear=1 and qcw_done=1 (PLL idle), then go to COOLDOWN with the counter reloaded.
REQ-031 qcw_phase_shift holds its last value outside RUN; it is reset to 0 on entry to IDLE.
REQ-032 PRECHARGE_CYCLES, SETTLE_CYCLES and COOLDOWN_CYCLES shall each be at least 1; a value of 1 gives a one-cycle dwell.
REQ-033 relay_precharge and relay_main shall never both be 1 in the same cycle.

Reset
REQ-034 Asynchronous assertion of reset_n=0 forces IDLE; all outputs go to 0 and the counter to 0 immediately, including mid-burst.
REQ-035 Deassertion takes effect on the next clk edge; the design relies on externally synchronised release.

Configuration
REQ-036 Macro QCW_SEQ_PHASE_RAMP_EN: when defined, the ramp of REQ-025 is active.
REQ-037 When QCW_SEQ_PHASE_RAMP_EN is undefined, qcw_phase_shift = cfg_phase_start for the whole burst; cfg_phase_step and cfg_phase_max are ignored and no ramp logic is synthesised.

Verification
REQ-038 Params 4/2/5, limit=3, start=10, step=20, max=45, fire_req=1 -> precharge 4 cycles, main 2 cycles, one qcw_start pulse, phase 10->30->45->45, cooldown 5 cycles, then IDLE.
REQ-039 fire_req=1 with uvlo_ok=0 -> no fire_ack, relays stay 0, busy=0.
REQ-040 qcw_fault pulse in RUN at the same cycle as qcw_done -> FAULT, relays 0, fault_latched=1; fault_clear with qcw_done=1 -> COOLDOWN then IDLE.
REQ-041 reset_n=0 asserted mid-RUN between clock edges -> all outputs 0 before the next edge.
REQ-042 start=250, step=10 -> phase saturates at cfg_phase_max (255), no wrap.
REQ-043 Macro undefined, same stimulus as REQ-038 -> qcw_phase_shift=10 for the whole burst.
